// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    FETCH = 2'd1,
    IDLE  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'hBFC00000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'hBFC00380;
  localparam logic [31:0] PC_INC        = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/redirect_pend.sv
// Holds a redirect target that arrived while a fetch was still waiting for its ack.
module redirect_pend
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] pc
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, redirects and optional traps.
// Define FETCH_CTRL_TRAP_EN to add the trap_req/epc ports and the trap vector.
module fetch_ctrl
  import fetch_pkg::*;
#(
`ifdef FETCH_CTRL_TRAP_EN
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF,
`endif
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic        trap_req,
  output logic [31:0] epc,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  inst_pc4_q, inst_pc4_d;
`ifdef FETCH_CTRL_TRAP_EN
  logic [31:0]  epc_q, epc_d;
`endif

  logic         pend_load, pend_clear, pend_valid;
  logic [31:0]  pend_load_pc, pend_pc;

  redirect_pend u_pend (
    .clk     (clk),
    .rst     (rst),
    .load    (pend_load),
    .clear   (pend_clear),
    .load_pc (pend_load_pc),
    .valid   (pend_valid),
    .pc      (pend_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    inst_valid_d = 1'b0;
    inst_pc_d    = inst_pc_q;
    inst_pc4_d   = inst_pc4_q;
    pend_load    = 1'b0;
    pend_clear   = 1'b0;
    pend_load_pc = align_pc(redirect_pc);
`ifdef FETCH_CTRL_TRAP_EN
    epc_d        = epc_q;
`endif
    unique case (state_q)
      RST_S: begin
        state_d = FETCH;
        req_d   = 1'b1;
        pc_d    = RESET_VEC;
      end
      FETCH: begin
        if (imem_ack) begin
          // Any redirect seen during this fetch means the returned word is on a dead path.
          inst_valid_d = !(redirect_valid || pend_valid);
          if (inst_valid_d) begin
            inst_pc_d  = pc_q;
            inst_pc4_d = pc_q + PC_INC;
          end
          if (redirect_valid)  pc_d = align_pc(redirect_pc);
          else if (pend_valid) pc_d = pend_pc;
          else                 pc_d = pc_q + PC_INC;
          pend_clear = 1'b1;
          state_d    = stall ? IDLE : FETCH;
          req_d      = !stall;
        end else if (redirect_valid) begin
          pend_load = 1'b1;
        end
`ifdef FETCH_CTRL_TRAP_EN
        if (trap_req) begin
          epc_d        = pc_q;
          inst_valid_d = 1'b0;
          inst_pc_d    = inst_pc_q;
          inst_pc4_d   = inst_pc4_q;
          // Without an ack the address must stay put, so the trap target replaces any pending redirect.
          if (imem_ack) begin
            pc_d = TRAP_VEC;
          end else begin
            pend_load    = 1'b1;
            pend_load_pc = TRAP_VEC;
          end
        end
`endif
      end
      IDLE: begin
        if (redirect_valid) pc_d = align_pc(redirect_pc);
`ifdef FETCH_CTRL_TRAP_EN
        if (trap_req) begin
          epc_d = pc_q;
          pc_d  = TRAP_VEC;
        end
`endif
        if (!stall) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = RST_S;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_S;
      pc_q         <= RESET_VEC;
      req_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= RESET_VEC;
      inst_pc4_q   <= RESET_VEC + PC_INC;
`ifdef FETCH_CTRL_TRAP_EN
      epc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_pc4_q   <= inst_pc4_d;
`ifdef FETCH_CTRL_TRAP_EN
      epc_q        <= epc_d;
`endif
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc4_q;
`ifdef FETCH_CTRL_TRAP_EN
  assign epc        = epc_q;
`endif

endmodule
